// File: rtl/core_pkg.sv
// Purpose: shared encodings for the RV32I multi-cycle sequencer (states, opcodes,
//          writeback-source codes, decoded-instruction record).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } seqState_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_UIMM = 2'd1;
  localparam logic [1:0] WB_LOAD = 2'd2;
  localparam logic [1:0] WB_PC4  = 2'd3;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_UIMM    = 3'd1,
    CL_ALU     = 3'd2,
    CL_LOAD    = 3'd3,
    CL_STORE   = 3'd4,
    CL_JUMP    = 3'd5,
    CL_BRANCH  = 3'd6
  } opClass_t;

  typedef struct packed {
    opClass_t   opClass;
    logic       writesRd;
    logic       usesMem;
    logic       isJump;
    logic       isBranch;
    logic       illegal;
    logic [1:0] wbSel;
  } opInfo_t;

endpackage

// File: rtl/core_opdec.sv
// Purpose: classify a RV32I major opcode into the attributes the sequencer needs.
// Latency: purely combinational.
// Backpressure: none.
// Ports: opcode (7-bit major opcode from IR[6:0]) -> info (decoded record).
module core_opdec
  import core_pkg::*;
(
  input  logic [6:0] opcode,
  output opInfo_t    info
);

  always_comb begin
    info         = '0;
    info.opClass = CL_ILLEGAL;
    info.illegal = 1'b1;
    info.wbSel   = WB_ALU;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        info.opClass  = CL_UIMM;
        info.illegal  = 1'b0;
        info.writesRd = 1'b1;
        info.wbSel    = WB_UIMM;
      end
      OP_OPIMM, OP_OP: begin
        info.opClass  = CL_ALU;
        info.illegal  = 1'b0;
        info.writesRd = 1'b1;
        info.wbSel    = WB_ALU;
      end
      OP_LOAD: begin
        info.opClass  = CL_LOAD;
        info.illegal  = 1'b0;
        info.writesRd = 1'b1;
        info.usesMem  = 1'b1;
        info.wbSel    = WB_LOAD;
      end
      OP_STORE: begin
        info.opClass  = CL_STORE;
        info.illegal  = 1'b0;
        info.usesMem  = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        info.opClass  = CL_JUMP;
        info.illegal  = 1'b0;
        info.writesRd = 1'b1;
        info.isJump   = 1'b1;
        info.wbSel    = WB_PC4;
      end
      OP_BRANCH: begin
        info.opClass  = CL_BRANCH;
        info.illegal  = 1'b0;
        info.isBranch = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_seq_ctrl.sv
// Purpose: multi-cycle RV32I sequencer (FETCH/DECODE/EXEC/MEM/WB) owning PC, IR,
//          redirect state and the retired-instruction counter; halts on illegal
//          opcodes or misaligned control-flow targets.
// Latency: 4 cycles per non-memory instruction, 5 for load/store, +1 per ack wait cycle.
// Backpressure: FETCH and MEM hold their request high until the matching ack;
//               acks arriving in any other state are ignored.
// Ports: iCLK/iRST clock and sync reset; oIMEM_REQ/iIMEM_ACK/iIMEM_DATA fetch
//        handshake; oDMEM_REQ/oDMEM_WE/iDMEM_ACK data handshake; iBR_TAKEN and
//        iPC_TARGET from the datapath in EXEC; oIR/oPC/oRD current instruction;
//        oRF_WE/oWB_SEL writeback control; oHALT sticky halt; oINSTRET counter.
module core_seq_ctrl
  import core_pkg::*;
#(
  parameter int unsigned       PC_W     = 8,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic            iCLK,
  input  logic            iRST,
  output logic            oIMEM_REQ,
  input  logic            iIMEM_ACK,
  input  logic [31:0]     iIMEM_DATA,
  output logic            oDMEM_REQ,
  output logic            oDMEM_WE,
  input  logic            iDMEM_ACK,
  input  logic            iBR_TAKEN,
  input  logic [PC_W-1:0] iPC_TARGET,
  output logic [31:0]     oIR,
  output logic [PC_W-1:0] oPC,
  output logic            oRF_WE,
  output logic [4:0]      oRD,
  output logic [1:0]      oWB_SEL,
  output logic            oHALT,
  output logic [31:0]     oINSTRET
);

  seqState_t state, stateNext;

  logic [PC_W-1:0] pcQ;
  logic [31:0]     irQ;
  logic [31:0]     instretQ;

  // Instruction class captured in DECODE so EXEC/MEM/WB do not depend on
  // the decoder staying valid.
  opClass_t clsQ;
  logic     writesRdQ;
  logic     usesMemQ;
  logic     isJumpQ;
  logic     isBranchQ;

  logic            redirectQ;
  logic [PC_W-1:0] targetQ;

  opInfo_t decInfo;
  logic    redirNow;
  logic    misaligned;

  core_opdec uOpdec (
    .opcode (irQ[6:0]),
    .info   (decInfo)
  );

  assign redirNow   = isJumpQ | (isBranchQ & iBR_TAKEN);
  assign misaligned = redirNow & (iPC_TARGET[1:0] != 2'b00);

  // IR is held from DECODE through WB, so the combinational decode gives a
  // stable writeback select; after reset IR=0 decodes as illegal -> WB_ALU (0).
  assign oWB_SEL  = decInfo.wbSel;
  assign oIR      = irQ;
  assign oPC      = pcQ;
  assign oRD      = irQ[11:7];
  assign oINSTRET = instretQ;
  assign oHALT    = (state == ST_HALT);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= ST_IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    oIMEM_REQ = 1'b0;
    oDMEM_REQ = 1'b0;
    oDMEM_WE  = 1'b0;
    oRF_WE    = 1'b0;
    case (state)
      ST_IDLE:   stateNext = ST_FETCH;
      ST_FETCH: begin
        oIMEM_REQ = 1'b1;
        if (iIMEM_ACK) stateNext = ST_DECODE;
      end
      ST_DECODE: stateNext = decInfo.illegal ? ST_HALT : ST_EXEC;
      ST_EXEC: begin
        if (misaligned)    stateNext = ST_HALT;
        else if (usesMemQ) stateNext = ST_MEM;
        else               stateNext = ST_WB;
      end
      ST_MEM: begin
        oDMEM_REQ = 1'b1;
        oDMEM_WE  = (clsQ == CL_STORE);
        if (iDMEM_ACK) stateNext = ST_WB;
      end
      ST_WB: begin
        oRF_WE    = writesRdQ & (irQ[11:7] != 5'd0);
        stateNext = ST_FETCH;
      end
      ST_HALT:   stateNext = ST_HALT;
      default:   stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pcQ       <= RESET_PC;
      irQ       <= '0;
      instretQ  <= '0;
      clsQ      <= CL_ILLEGAL;
      writesRdQ <= 1'b0;
      usesMemQ  <= 1'b0;
      isJumpQ   <= 1'b0;
      isBranchQ <= 1'b0;
      redirectQ <= 1'b0;
      targetQ   <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (iIMEM_ACK) irQ <= iIMEM_DATA;
        end
        ST_DECODE: begin
          clsQ      <= decInfo.opClass;
          writesRdQ <= decInfo.writesRd;
          usesMemQ  <= decInfo.usesMem;
          isJumpQ   <= decInfo.isJump;
          isBranchQ <= decInfo.isBranch;
        end
        ST_EXEC: begin
          redirectQ <= redirNow;
          targetQ   <= iPC_TARGET;
        end
        ST_WB: begin
          pcQ      <= redirectQ ? targetQ : pcQ + PC_W'(4);
          instretQ <= instretQ + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
